// File: rtl/rv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : rv_pkg                                                       |
// | Brief    : Shared core constants: datapath widths and ALU op codes.    |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  // ALU operation codes, shared between the ID/EX stage and rv_alu
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

endpackage
`default_nettype wire

// File: rtl/rv_fwd_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : rv_fwd_mux                                                   |
// | Brief    : Per-source operand forwarding from MEM/WB plus load-use     |
// |            hazard and WB-refresh detection.                             |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module rv_fwd_mux
  import rv_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int RA_W_P = RA_W
) (
  input  logic [RA_W_P-1:0] rs_addr_i,
  input  logic [XLEN_P-1:0] held_val_i,
  input  logic              rs_used_i,
  input  logic              mem_fwd_we_i,
  input  logic              mem_fwd_load_i,
  input  logic [RA_W_P-1:0] mem_fwd_rd_i,
  input  logic [XLEN_P-1:0] mem_fwd_data_i,
  input  logic              wb_fwd_we_i,
  input  logic [RA_W_P-1:0] wb_fwd_rd_i,
  input  logic [XLEN_P-1:0] wb_fwd_data_i,
  output logic [XLEN_P-1:0] fwd_val_o,
  output logic              load_haz_o,
  output logic              wb_hit_o
);

  logic w_rs_nz;
  logic w_mem_rd_match;
  logic w_mem_hit;

  // x0 is hard-wired zero, so it never matches a producer
  assign w_rs_nz        = (rs_addr_i != '0);
  assign w_mem_rd_match = mem_fwd_we_i & (mem_fwd_rd_i == rs_addr_i) & w_rs_nz;

  // A load in MEM has no data yet: it cannot forward, it can only stall
  assign w_mem_hit  = w_mem_rd_match & ~mem_fwd_load_i;
  assign load_haz_o = w_mem_rd_match & mem_fwd_load_i & rs_used_i;
  assign wb_hit_o   = wb_fwd_we_i & (wb_fwd_rd_i == rs_addr_i) & w_rs_nz;

  // Youngest producer wins: MEM before WB before the held register value
  always_comb begin
    fwd_val_o = held_val_i;
    if (w_mem_hit) begin
      fwd_val_o = mem_fwd_data_i;
    end else if (wb_hit_o) begin
      fwd_val_o = wb_fwd_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_id_ex_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : rv_id_ex_stage                                               |
// | Brief    : ID/EX pipeline register with valid/ready handshake, MEM/WB  |
// |            forwarding and load-use stall in front of the ALU.          |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module rv_id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int RA_W_P = RA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  // decode side
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [XLEN_P-1:0] id_pc_i,
  input  logic [XLEN_P-1:0] id_rs1_val_i,
  input  logic [XLEN_P-1:0] id_rs2_val_i,
  input  logic [XLEN_P-1:0] id_imm_i,
  input  logic [RA_W_P-1:0] id_rs1_addr_i,
  input  logic [RA_W_P-1:0] id_rs2_addr_i,
  input  logic [RA_W_P-1:0] id_rd_addr_i,
  input  logic [3:0]        id_alu_ctrl_i,
  input  logic              id_use_imm_i,
  input  logic              id_use_pc_i,
  input  logic              id_rd_we_i,
  // forwarding sources
  input  logic              mem_fwd_we_i,
  input  logic              mem_fwd_load_i,
  input  logic [RA_W_P-1:0] mem_fwd_rd_i,
  input  logic [XLEN_P-1:0] mem_fwd_data_i,
  input  logic              wb_fwd_we_i,
  input  logic [RA_W_P-1:0] wb_fwd_rd_i,
  input  logic [XLEN_P-1:0] wb_fwd_data_i,
  // execute side
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN_P-1:0] ex_a_o,
  output logic [XLEN_P-1:0] ex_b_o,
  output logic [3:0]        ex_alu_ctrl_o,
  output logic [XLEN_P-1:0] ex_store_data_o,
  output logic [XLEN_P-1:0] ex_pc_o,
  output logic [RA_W_P-1:0] ex_rd_addr_o,
  output logic              ex_rd_we_o
);

  // Held instruction
  logic              valid_q,    valid_d;
  logic [XLEN_P-1:0] pc_q,       pc_d;
  logic [XLEN_P-1:0] rs1_val_q,  rs1_val_d;
  logic [XLEN_P-1:0] rs2_val_q,  rs2_val_d;
  logic [XLEN_P-1:0] imm_q,      imm_d;
  logic [RA_W_P-1:0] rs1_addr_q, rs1_addr_d;
  logic [RA_W_P-1:0] rs2_addr_q, rs2_addr_d;
  logic [RA_W_P-1:0] rd_addr_q,  rd_addr_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic              use_imm_q,  use_imm_d;
  logic              use_pc_q,   use_pc_d;
  logic              rd_we_q,    rd_we_d;

  logic [XLEN_P-1:0] fwd_rs1;
  logic [XLEN_P-1:0] fwd_rs2;
  logic              haz_rs1;
  logic              haz_rs2;
  logic              wb_hit_rs1;
  logic              wb_hit_rs2;
  logic              hazard;
  logic              advance;
  logic              capture;

  // rs1 only matters for hazards when it actually feeds operand A
  rv_fwd_mux #(.XLEN_P(XLEN_P), .RA_W_P(RA_W_P)) u_fwd_rs1 (
    .rs_addr_i      (rs1_addr_q),
    .held_val_i     (rs1_val_q),
    .rs_used_i      (~use_pc_q),
    .mem_fwd_we_i   (mem_fwd_we_i),
    .mem_fwd_load_i (mem_fwd_load_i),
    .mem_fwd_rd_i   (mem_fwd_rd_i),
    .mem_fwd_data_i (mem_fwd_data_i),
    .wb_fwd_we_i    (wb_fwd_we_i),
    .wb_fwd_rd_i    (wb_fwd_rd_i),
    .wb_fwd_data_i  (wb_fwd_data_i),
    .fwd_val_o      (fwd_rs1),
    .load_haz_o     (haz_rs1),
    .wb_hit_o       (wb_hit_rs1)
  );

  // rs2 always counts: even with an immediate B it is the store data
  rv_fwd_mux #(.XLEN_P(XLEN_P), .RA_W_P(RA_W_P)) u_fwd_rs2 (
    .rs_addr_i      (rs2_addr_q),
    .held_val_i     (rs2_val_q),
    .rs_used_i      (1'b1),
    .mem_fwd_we_i   (mem_fwd_we_i),
    .mem_fwd_load_i (mem_fwd_load_i),
    .mem_fwd_rd_i   (mem_fwd_rd_i),
    .mem_fwd_data_i (mem_fwd_data_i),
    .wb_fwd_we_i    (wb_fwd_we_i),
    .wb_fwd_rd_i    (wb_fwd_rd_i),
    .wb_fwd_data_i  (wb_fwd_data_i),
    .fwd_val_o      (fwd_rs2),
    .load_haz_o     (haz_rs2),
    .wb_hit_o       (wb_hit_rs2)
  );

  // HOLD vs HAZ is purely combinational; only the valid bit is state
  assign hazard     = valid_q & (haz_rs1 | haz_rs2);
  assign ex_valid_o = valid_q & ~hazard;
  assign advance    = ex_valid_o & ex_ready_i;
  assign id_ready_o = ~valid_q | advance;
  assign capture    = id_valid_i & id_ready_o & ~flush_i;

  // Next-state: capture a new instruction, or refresh held sources from WB
  always_comb begin
    pc_d       = pc_q;
    rs1_val_d  = rs1_val_q;
    rs2_val_d  = rs2_val_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    alu_ctrl_d = alu_ctrl_q;
    use_imm_d  = use_imm_q;
    use_pc_d   = use_pc_q;
    rd_we_d    = rd_we_q;
    valid_d    = valid_q;

    if (capture) begin
      pc_d       = id_pc_i;
      rs1_val_d  = id_rs1_val_i;
      rs2_val_d  = id_rs2_val_i;
      imm_d      = id_imm_i;
      rs1_addr_d = id_rs1_addr_i;
      rs2_addr_d = id_rs2_addr_i;
      rd_addr_d  = id_rd_addr_i;
      alu_ctrl_d = id_alu_ctrl_i;
      use_imm_d  = id_use_imm_i;
      use_pc_d   = id_use_pc_i;
      rd_we_d    = id_rd_we_i;
    end else if (valid_q) begin
      // The WB producer retires after this edge; keep its value locally
      if (wb_hit_rs1) begin
        rs1_val_d = wb_fwd_data_i;
      end
      if (wb_hit_rs2) begin
        rs2_val_d = wb_fwd_data_i;
      end
    end

    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with asynchronous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      alu_ctrl_q <= '0;
      use_imm_q  <= 1'b0;
      use_pc_q   <= 1'b0;
      rd_we_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_val_q  <= rs1_val_d;
      rs2_val_q  <= rs2_val_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      alu_ctrl_q <= alu_ctrl_d;
      use_imm_q  <= use_imm_d;
      use_pc_q   <= use_pc_d;
      rd_we_q    <= rd_we_d;
    end
  end

  // Operand selection toward EX
  assign ex_a_o          = use_pc_q  ? pc_q  : fwd_rs1;
  assign ex_b_o          = use_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data_o = fwd_rs2;
  assign ex_alu_ctrl_o   = alu_ctrl_q;
  assign ex_pc_o         = pc_q;
  assign ex_rd_addr_o    = rd_addr_q;
  assign ex_rd_we_o      = rd_we_q & ex_valid_o;

endmodule
`default_nettype wire

// File: doc/rv_id_ex_stage.md
Name: rv_id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures a decoded instruction from decode and holds it under a valid/ready handshake.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and holds a bubble on a load-use hazard.
- Drives the ALU operands a/b, the 4-bit ALU control, and destination info to EX.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- flush_i  input  1  kill the held instruction (branch taken or exception).
- id_valid_i  input  1  decode presents an instruction.
- id_ready_o  output  1  stage can accept this cycle.
- id_pc_i  input  XLEN  instruction PC.
- id_rs1_val_i / id_rs2_val_i  input  XLEN  register file read data.
- id_imm_i  input  XLEN  sign-extended immediate.
- id_rs1_addr_i / id_rs2_addr_i / id_rd_addr_i  input  RA_W  register addresses.
- id_alu_ctrl_i  input  4  ALU operation code (from shared package).
- id_use_imm_i  input  1  B = immediate.
- id_use_pc_i  input  1  A = PC.
- id_rd_we_i  input  1  instruction writes rd.
- mem_fwd_we_i / mem_fwd_load_i  input  1  MEM stage writes rd / MEM stage is a load (data not yet available).
- mem_fwd_rd_i  input  RA_W  MEM destination register.
- mem_fwd_data_i  input  XLEN  MEM result.
- wb_fwd_we_i  input  1  WB writes rd.
- wb_fwd_rd_i  input  RA_W  WB destination register.
- wb_fwd_data_i  input  XLEN  WB result.
- ex_valid_o  output  1  operands valid for EX.
- ex_ready_i  input  1  EX consumes this cycle.
- ex_a_o / ex_b_o  output  XLEN  ALU operands.
- ex_alu_ctrl_o  output  4  ALU control.
- ex_store_data_o  output  XLEN  forwarded rs2 value, used for stores.
- ex_pc_o  output  XLEN  held PC.
- ex_rd_addr_o  output  RA_W  held rd.
- ex_rd_we_o  output  1  held rd write enable.

Behaviour:
- Reset (async, rst_i=1):
  - Held valid bit cleared; all held fields cleared.
  - ex_valid_o=0; ex_a_o, ex_b_o, ex_store_data_o, ex_pc_o = 0; ex_alu_ctrl_o=0; ex_rd_addr_o=0; ex_rd_we_o=0.
  - id_ready_o=1 immediately.
- States:
  - EMPTY: held valid=0.
  - HOLD: held valid=1, no hazard.
  - HAZ: held valid=1 and load-use hazard present.
  - HOLD/HAZ is decided combinationally each cycle; only the valid bit is registered.
- Hazard detection:
  - hazard = held valid & mem_fwd_we_i & mem_fwd_load_i & mem_fwd_rd_i!=0.
  - Further requires (mem_fwd_rd_i==rs1 & !use_pc) or (mem_fwd_rd_i==rs2).
  - rs2 counts even when use_imm=1, because of store data.
- Handshake:
  - ex_valid_o = held valid & !hazard.
  - advance = ex_valid_o & ex_ready_i.
  - id_ready_o = !held valid | advance.
  - HAZ therefore back-pressures decode.
- Capture, latency 1:
  - On id_valid_i & id_ready_o & !flush_i, all id_* fields are registered and valid=1 at the next edge.
  - On advance without a new capture: valid=0.
- Flush:
  - flush_i=1 sets valid=0 at the next edge.
  - Flush wins over a simultaneous capture: the incoming instruction is dropped.
  - id_ready_o is not gated by flush_i.
- Forwarding, combinational on outputs, applied per source (rs1, rs2):
  - Priority: MEM match (we, rd==rs, rs!=0, not a load) > WB match (we, rd==rs, rs!=0) > held value.
  - x0 is never forwarded.
  - A forwarded value of x0 always reads as held value 0.
- Refresh while stalled:
  - Each edge where held valid=1 and no capture occurs, a WB match overwrites the held rs value with wb_fwd_data_i.
  - This keeps the value correct after the producer retires.
  - The refresh also applies in HAZ.
- Operand selection:
  - ex_a_o = use_pc ? pc : fwd_rs1.
  - ex_b_o = use_imm ? imm : fwd_rs2.
  - ex_store_data_o = fwd_rs2.
- Outputs while ex_valid_o=0 are don't-care except ex_rd_we_o. ex_rd_we_o is gated: held rd_we & ex_valid_o.
- Simultaneous advance and capture: the new instruction replaces the old one with no bubble, giving full throughput.

Decomposition:
- Shared package rv_pkg:
  - XLEN, RA_W.
  - 4-bit ALU_* operation codes with unique values (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA), shared with rv_alu.
- Sub-module rv_fwd_mux, instantiated twice.
  - Inputs: rs address, held value, MEM/WB forward ports.
  - Outputs: forwarded value, load-hazard flag.

Test Plan:
- Reset mid-HOLD: assert rst_i asynchronously -> ex_valid_o=0 and all outputs 0 without waiting for a clock edge; id_ready_o=1.
- Back-to-back ADD x3=x1+x2 (rs1=5, rs2=7), ex_ready_i=1 -> ex_a_o=5, ex_b_o=7 one cycle after capture; id_ready_o stays 1; a second instruction follows with no bubble.
- Forward priority: rs1=x4; MEM writes x4=0x11 and WB writes x4=0x22 in the same cycle -> ex_a_o=0x11. With MEM rd=x0 carrying 0x33 and rs1=x0 -> ex_a_o=0.
- Load-use: MEM is a load to x6, held instruction uses rs2=x6 -> ex_valid_o=0 and id_ready_o=0 for one cycle. Next cycle WB x6=0x99 -> ex_b_o=0x99 and ex_valid_o=1.
- Stall refresh: ex_ready_i=0 for 3 cycles; WB writes rs1=x8 with 0xABCD in cycle 1 and forwarding sources idle afterwards -> ex_a_o=0xABCD in cycles 2-3.
- Flush with capture: flush_i=1 while id_valid_i=1 and id_ready_o=1 -> ex_valid_o=0 next cycle; the dropped instruction never appears.
